// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port round-robin arbiter in front of a single-outstanding
//             memory interface. Each requester owns a one-deep pending slot
//             that latches op/addr/wdata from a one-cycle read/write pulse.
//             The arbiter issues one held-level memory command at a time and
//             returns a one-cycle resp pulse (plus read data) to the owner.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                 clock, asynchronous active-high reset
//    p0_*/p1_* read, write    one-cycle request pulses (port 0 = core control,
//                             port 1 = DMA/debug master)
//    p0_*/p1_* addr, wdata    request address/store data, pulse cycle only
//    p0_*/p1_* resp           one-cycle completion pulse
//    p0_*/p1_* rdata          read data, held until next read completion
//    mem_read, mem_write      memory command, held until mem_resp
//    mem_addr, mem_wdata      registered memory address / store data
//    mem_resp, mem_rdata      memory completion pulse and its read data
//    grant                    port being serviced (valid while busy)
//    busy                     memory transaction outstanding
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_resp,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_resp,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              grant,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY0 = 2'd1;
    localparam logic [1:0] S_BUSY1 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    // ------------------------------------------------------------------------
    // Requester inputs gathered into arrays so both slots share one body
    // ------------------------------------------------------------------------
    logic [1:0]        w_req_read;
    logic [1:0]        w_req_write;
    logic [ADDR_W-1:0] w_req_addr  [2];
    logic [DATA_W-1:0] w_req_wdata [2];

    assign w_req_read     = {p1_read,  p0_read};
    assign w_req_write    = {p1_write, p0_write};
    assign w_req_addr[0]  = p0_addr;
    assign w_req_addr[1]  = p1_addr;
    assign w_req_wdata[0] = p0_wdata;
    assign w_req_wdata[1] = p1_wdata;

    // Slot contents as seen by the arbiter
    logic [1:0]        w_pend;
    logic [1:0]        w_op_write;
    logic [ADDR_W-1:0] w_slot_addr  [2];
    logic [DATA_W-1:0] w_slot_wdata [2];

    // Transaction control decoded from the FSM
    logic w_start;        // IDLE -> BUSYx on this edge
    logic w_start_port;   // which slot is being launched
    logic w_done;         // BUSYx sampling mem_resp on this edge
    logic w_done_port;    // which slot is completing

    // ------------------------------------------------------------------------
    // Pending slots. A pulse is only accepted while the slot is empty; since
    // the slot is still full on its own completion edge, a pulse arriving on
    // that edge is dropped too. Write wins when read and write pulse together.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic              r_pend;
            logic              r_op_write;
            logic [ADDR_W-1:0] r_addr;
            logic [DATA_W-1:0] r_wdata;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pend     <= 1'b0;
                    r_op_write <= 1'b0;
                    r_addr     <= '0;
                    r_wdata    <= '0;
                end else if (w_done && (w_done_port == gi[0])) begin
                    r_pend <= 1'b0;
                end else if ((w_req_read[gi] || w_req_write[gi]) && !r_pend) begin
                    r_pend     <= 1'b1;
                    r_op_write <= w_req_write[gi];
                    r_addr     <= w_req_addr[gi];
                    r_wdata    <= w_req_wdata[gi];
                end
            end

            assign w_pend[gi]       = r_pend;
            assign w_op_write[gi]   = r_op_write;
            assign w_slot_addr[gi]  = r_addr;
            assign w_slot_wdata[gi] = r_wdata;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    logic r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state. On a tie the port that was not served last wins; the
    // reset value of last_grant (1) hands the first tie to port 0.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_start_port = 1'b0;
        w_done       = 1'b0;
        w_done_port  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pend[0] && w_pend[1]) begin
                    w_start      = 1'b1;
                    w_start_port = ~r_last_grant;
                end else if (w_pend[0]) begin
                    w_start      = 1'b1;
                    w_start_port = 1'b0;
                end else if (w_pend[1]) begin
                    w_start      = 1'b1;
                    w_start_port = 1'b1;
                end
                if (w_start) begin
                    w_state_next = w_start_port ? S_BUSY1 : S_BUSY0;
                end
            end

            // No timeout: a busy state only leaves on mem_resp.
            S_BUSY0: begin
                if (mem_resp) begin
                    w_done       = 1'b1;
                    w_done_port  = 1'b0;
                    w_state_next = S_IDLE;
                end
            end

            S_BUSY1: begin
                if (mem_resp) begin
                    w_done       = 1'b1;
                    w_done_port  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered memory command, completion signalling and read data.
    // The command is loaded only on entry to BUSYx and held untouched until
    // completion, so it stays stable for as long as memory takes.
    // ------------------------------------------------------------------------
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_grant;
    logic              r_busy;
    logic [1:0]        r_resp;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_grant      <= 1'b0;
            r_busy       <= 1'b0;
            r_resp       <= 2'b00;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_last_grant <= 1'b1;
        end else begin
            // resp is a single-cycle pulse
            r_resp <= 2'b00;

            if (w_start) begin
                r_mem_addr  <= w_slot_addr[w_start_port];
                r_mem_wdata <= w_slot_wdata[w_start_port];
                r_mem_read  <= ~w_op_write[w_start_port];
                r_mem_write <= w_op_write[w_start_port];
                r_grant     <= w_start_port;
                r_busy      <= 1'b1;
            end else if (w_done) begin
                r_mem_read           <= 1'b0;
                r_mem_write          <= 1'b0;
                r_busy               <= 1'b0;
                r_last_grant         <= w_done_port;
                r_resp[w_done_port]  <= 1'b1;
                // Writes leave the requester's read data untouched
                if (r_mem_read) begin
                    if (w_done_port) begin
                        r_rdata1 <= mem_rdata;
                    end else begin
                        r_rdata0 <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign grant     = r_grant;
    assign busy      = r_busy;
    assign p0_resp   = r_resp[0];
    assign p1_resp   = r_resp[1];
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter. Expected memory
//             commands are queued as requests are driven and popped when the
//             arbiter issues them; read data is tracked per port by a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_resp, p1_resp;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write, mem_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        grant, busy;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_read   (p0_read),
        .p0_write  (p0_write),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_resp   (p0_resp),
        .p0_rdata  (p0_rdata),
        .p1_read   (p1_read),
        .p1_write  (p1_write),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_resp   (p1_resp),
        .p1_rdata  (p1_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        exp_q[$];
    cmd_t        cur;
    logic [31:0] exp_rdata [2];
    int          n_assert;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        p0_read  = 1'b0;
        p0_write = 1'b0;
        p1_read  = 1'b0;
        p1_write = 1'b0;
    endtask

    // Drive a request pulse for port p in the current cycle; queue the
    // command it should produce when it is expected to be accepted.
    task automatic set_req(input int p, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d, input bit expect_cmd);
        cmd_t c;
        if (p == 0) begin
            p0_read = rd; p0_write = wr; p0_addr = a; p0_wdata = d;
        end else begin
            p1_read = rd; p1_write = wr; p1_addr = a; p1_wdata = d;
        end
        if (expect_cmd) begin
            c.port  = p;
            c.wr    = wr;
            c.addr  = a;
            c.wdata = d;
            exp_q.push_back(c);
        end
    endtask

    task automatic step();
        tick();
        clear_reqs();
    endtask

    // Wait (bounded) for a memory command and check it against the scoreboard
    task automatic wait_cmd();
        int k;
        k = 0;
        while (!(mem_read || mem_write) && k < 20) begin
            tick();
            k++;
        end
        chk("cmd_seen", 32'(mem_read | mem_write), 32'd1);
        if (mem_read || mem_write) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 32'(mem_read | mem_write), 32'd0);
            end else begin
                cur = exp_q.pop_front();
                chk("cmd_grant", 32'(grant), 32'(cur.port));
                chk("cmd_busy",  32'(busy),  32'd1);
                chk("cmd_read",  32'(mem_read),  32'(!cur.wr));
                chk("cmd_write", 32'(mem_write), 32'(cur.wr));
                chk("cmd_addr",  mem_addr, cur.addr);
                if (cur.wr) chk("cmd_wdata", mem_wdata, cur.wdata);
            end
        end
    endtask

    // Hold the command for dly cycles, pulse mem_resp, then check the
    // completion cycle. dup selects a port that pulses on the completion edge.
    task automatic respond(input int dly, input logic [31:0] rd, input int dup);
        repeat (dly) begin
            tick();
            chk("cmd_stable_addr", mem_addr, cur.addr);
        end
        mem_resp  = 1'b1;
        mem_rdata = rd;
        if (dup == 0) begin p0_read = 1'b1; p0_addr = 32'hBAD0; end
        if (dup == 1) begin p1_read = 1'b1; p1_addr = 32'hBAD1; end
        tick();
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
        clear_reqs();
        if (!cur.wr) exp_rdata[cur.port] = rd;
        chk("resp_p0",   32'(p0_resp), 32'(cur.port == 0));
        chk("resp_p1",   32'(p1_resp), 32'(cur.port == 1));
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_idle", 32'(mem_read | mem_write), 32'd0);
        chk("rdata_p0",  p0_rdata, exp_rdata[0]);
        chk("rdata_p1",  p1_rdata, exp_rdata[1]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        clear_reqs();
        p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_mem_read",  32'(mem_read),  32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_grant",     32'(grant),     32'd0);
        chk("rst_resp",      32'({p1_resp, p0_resp}), 32'd0);
        chk("rst_rdata0",    p0_rdata, 32'd0);
        chk("rst_rdata1",    p1_rdata, 32'd0);
        chk("rst_mem_addr",  mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        tick();

        // Single read: command appears two cycles after the pulse
        set_req(0, 1, 0, 32'h100, 32'h0, 1);
        step();
        chk("lat_n1", 32'(mem_read), 32'd0);
        tick();
        chk("lat_n2", 32'(mem_read), 32'd1);
        wait_cmd();
        respond(3, 32'hDEADBEEF, -1);
        tick();
        chk("resp_one_cycle", 32'(p0_resp), 32'd0);
        chk("rdata_hold",     p0_rdata, 32'hDEADBEEF);

        // Simultaneous requests after reset: port 0 first, then the write
        do_reset();
        set_req(0, 1, 0, 32'h10, 32'h0, 1);
        set_req(1, 0, 1, 32'h20, 32'h55, 1);
        step();
        wait_cmd();
        respond(2, 32'h12345678, -1);
        wait_cmd();
        respond(1, 32'hCAFEF00D, -1);
        chk("write_keeps_rdata1", p1_rdata, 32'h0);

        // Fairness: both ports re-request straight after each resp
        do_reset();
        set_req(0, 1, 0, 32'h1000, 32'h0, 1);
        set_req(1, 1, 0, 32'h2000, 32'h0, 1);
        step();
        for (int i = 0; i < 6; i++) begin
            wait_cmd();
            chk("rr_grant", 32'(grant), 32'(i % 2));
            respond(1, $urandom, -1);
            if (i < 4) set_req(cur.port, 1, 0, 32'h3000 + 32'(i), 32'h0, 1);
            step();
            if (i < 5) chk("rr_one_idle_gap", 32'(mem_read | mem_write), 32'd1);
        end

        // Duplicate pulses while busy and on the completion edge are dropped
        set_req(0, 1, 0, 32'h4, 32'h0, 1);
        step();
        wait_cmd();
        set_req(0, 1, 0, 32'h8, 32'h0, 0);
        step();
        respond(2, 32'h11112222, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("dup_no_cmd",  32'(mem_read | mem_write), 32'd0);
            chk("dup_no_resp", 32'(p0_resp), 32'd0);
        end

        // Other port captured while busy; read+write together means write
        set_req(0, 1, 0, 32'h60, 32'h0, 1);
        step();
        wait_cmd();
        set_req(1, 1, 1, 32'h30, 32'hA5, 1);
        step();
        respond(1, 32'h0BADF00D, -1);
        wait_cmd();
        chk("rw_is_write", 32'(mem_write), 32'd1);
        chk("rw_no_read",  32'(mem_read),  32'd0);
        respond(2, 32'h99999999, -1);

        // Reset in the middle of a write; late mem_resp is ignored
        set_req(1, 0, 1, 32'h40, 32'h77, 1);
        step();
        wait_cmd();
        rst = 1'b1;
        #1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        chk("arst_mem_write", 32'(mem_write), 32'd0);
        chk("arst_busy",      32'(busy), 32'd0);
        chk("arst_rdata0",    p0_rdata, exp_rdata[0]);
        tick();
        rst = 1'b0;
        tick();
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("arst_no_resp", 32'({p1_resp, p0_resp}), 32'd0);
            chk("arst_idle",    32'({busy, mem_read, mem_write}), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, memory data width in bits.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pX_read / pX_write (X=0,1)  input  1 each  one-cycle request pulses from requester X; port 0 is the core control unit, port 1 is the DMA/debug master.
REQ-006 pX_addr  input  ADDR_W, and pX_wdata  input  DATA_W  request address and store data, sampled in the pulse cycle only.
REQ-007 pX_resp  output  1  one-cycle completion pulse to requester X.
REQ-008 pX_rdata  output  DATA_W  read data for requester X; holds its value until the next read completion on port X.
REQ-009 mem_read / mem_write  output  1 each  memory command, held level until the memory responds.
REQ-010 mem_addr  output  ADDR_W, and mem_wdata  output  DATA_W  registered memory address and store data.
REQ-011 mem_resp  input  1, and mem_rdata  input  DATA_W  memory completion pulse and its read data, valid in the mem_resp cycle.
REQ-012 grant  output  1  index of the port being serviced; meaningful only while busy=1.
REQ-013 busy  output  1  a memory transaction is outstanding.

Function
REQ-014 Each port SHALL have one pending slot (pend, op, addr, wdata); a pulse sampled while pend=0 sets pend=1 and captures op, addr and wdata at that edge.
REQ-015 When read and write pulse in the same cycle, the captured op SHALL be write.
REQ-016 A pulse sampled while that port's pend=1 SHALL be ignored: no capture and no resp.
REQ-017 FSM states SHALL be IDLE, BUSY0 and BUSY1.
REQ-018 In IDLE with only portX pending, the FSM SHALL go to BUSYX on the next edge.
REQ-019 In IDLE with both ports pending, the FSM SHALL go to BUSY of the port not equal to last_grant (round-robin).
REQ-020 On entry to BUSYX, these outputs SHALL be registered from slot X: mem_addr, mem_wdata, mem_read=(op==read), mem_write=(op==write), grant=X and busy=1.
REQ-021 Minimum latency from a pulse in cycle N (port idle, arbiter IDLE) to mem_read/mem_write high SHALL be cycle N+2.
REQ-022 In BUSYX, mem_read/mem_write/mem_addr/mem_wdata SHALL stay stable until mem_resp is sampled high.
REQ-023 On the edge that samples mem_resp=1 in BUSYX, the arbiter SHALL:
  - clear mem_read, mem_write and busy;
  - clear pend X;
  - set last_grant=X;
  - assert pX_resp for exactly the following cycle;
  - load pX_rdata from mem_rdata, on reads only;
  - return to IDLE.
REQ-024 A write SHALL NOT modify pX_rdata.
REQ-025 mem_resp sampled in IDLE SHALL be ignored.
REQ-026 A port's pulse coinciding with that port's completion edge SHALL be ignored, since pend is still 1 when sampled.
REQ-027 The other port's pulse during any state SHALL be captured normally if its slot is empty.
REQ-028 Back-to-back transactions SHALL have at least one IDLE cycle between mem_resp and the next mem_read/mem_write.
REQ-029 There SHALL be no timeout: BUSYX waits indefinitely for mem_resp.

Reset
REQ-030 While rst=1, the following SHALL be 0 asynchronously:
  - state=IDLE and last_grant=1, so port 0 wins the first tie;
  - both pend;
  - pX_resp, pX_rdata;
  - mem_read, mem_write, mem_addr, mem_wdata;
  - grant, busy.
REQ-031 Reset mid-transaction SHALL drop all pending and in-flight requests with no resp issued; a mem_resp arriving after reset release SHALL be ignored, per REQ-025.

Verification
REQ-032 Single read: p0_read, p0_addr=0x100; mem_resp with mem_rdata=0xDEADBEEF 3 cycles after mem_read.
  -> mem_read high at N+2 with mem_addr=0x100;
  -> p0_resp one cycle after mem_resp, p0_rdata=0xDEADBEEF held afterwards.
REQ-033 Simultaneous: p0_read addr 0x10, p1_write addr 0x20 wdata 0x55, both in the same cycle after reset.
  -> port 0 is serviced first (grant=0);
  -> then port 1 with mem_write=1, mem_addr=0x20, mem_wdata=0x55;
  -> p1_rdata stays 0.
REQ-034 Fairness: both ports re-request immediately after each resp for 6 transactions.
  -> grant order 0,1,0,1,0,1;
  -> one IDLE cycle between each mem_resp and the next command.
REQ-035 Duplicate pulse: p0_read addr 0x4, then a second p0_read addr 0x8 while busy.
  -> exactly one memory read (addr 0x4) and one p0_resp.
REQ-036 Reset mid-op: rst asserted while BUSY1 with mem_write=1, then mem_resp pulsed after release.
  -> mem_write drops immediately;
  -> no p1_resp, state remains IDLE.
REQ-037 Read+write same cycle: p1_read=p1_write=1, addr 0x30, wdata 0xA5.
  -> mem_write=1, mem_read=0, mem_wdata=0xA5.
